// File: rtl/booth_product_accumulator.sv
// Accumulates N_TERMS signed 64-bit products per group into a saturating sum and
// buffers each completed group sum in a small first-word-fall-through FIFO.
module booth_product_accumulator #(
  parameter  int ACC_W      = 66,
  parameter  int N_TERMS    = 4,
  parameter  int FIFO_DEPTH = 2,
  localparam int CNT_W      = $clog2(N_TERMS + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [63:0]      Product,
  input  logic                    Product_Valid,
  input  logic                    Acc_Clear,
  output logic signed [ACC_W-1:0] Sum_Out,
  output logic                    Sum_Ovf,
  output logic                    Sum_Valid,
  input  logic                    Sum_Ready,
  output logic                    Drop,
  output logic [CNT_W-1:0]        Term_Cnt
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE, ACCUM} state_e;

  // Returns {overflow, saturated sum}; the ACC_W+1 bit sum cannot itself wrap.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [63:0] p);
    logic [ACC_W:0] w;
    w = {a[ACC_W-1], a} + {{(ACC_W + 1 - 64){p[63]}}, p};
    if (w[ACC_W] != w[ACC_W-1]) begin
      return w[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}}
                      : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
    return {1'b0, w[ACC_W-1:0]};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_W:0]       mem_q [FIFO_DEPTH];
  logic [ACC_W:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic [ACC_W:0]       hold_q, hold_d;
  logic                 drop_q, drop_d;

  logic [ACC_W:0]       step;
  logic [ACC_W:0]       head;
  logic [ACC_W:0]       out_w;
  logic                 last_term, push, pop, full, wr_en;

  assign step      = sat_add(acc_q, Product);
  assign last_term = (state_q == IDLE) ? (N_TERMS == 1) : (cnt_q == LAST_CNT);
  assign push      = Product_Valid && !Acc_Clear && last_term;
  assign head      = mem_q[rd_q];
  assign Sum_Valid = (fcnt_q != '0);
  assign pop       = Sum_Valid && Sum_Ready;
  assign full      = (fcnt_q == FULL_CNT);
  assign wr_en     = push && (!full || pop);
  assign out_w     = Sum_Valid ? head : hold_q;
  assign Sum_Out   = out_w[ACC_W-1:0];
  assign Sum_Ovf   = out_w[ACC_W];
  assign Drop      = drop_q;
  assign Term_Cnt  = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (Acc_Clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (Product_Valid) begin
      if (last_term) begin
        state_d = IDLE;
        cnt_d   = '0;
        acc_d   = '0;
        ovf_d   = 1'b0;
      end else begin
        state_d = ACCUM;
        cnt_d   = cnt_q + CNT_W'(1);
        acc_d   = step[ACC_W-1:0];
        ovf_d   = ovf_q | step[ACC_W];
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    fcnt_d = fcnt_q;
    hold_d = hold_q;
    drop_d = push && full && !pop;
    if (wr_en) begin
      mem_d[wr_q] = {ovf_q | step[ACC_W], step[ACC_W-1:0]};
      wr_d        = ptr_inc(wr_q);
    end
    if (pop) begin
      rd_d   = ptr_inc(rd_q);
      hold_d = head;
    end
    case ({wr_en, pop})
      2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      fcnt_q  <= '0;
      hold_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fcnt_q  <= fcnt_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench: vector table on an N_TERMS=4 instance plus hand sequences for
// saturation (N_TERMS=8 instance) and reset during a group with a buffered sum.
module tb_booth_product_accumulator;

  localparam int ACC_W = 66;

  typedef struct {
    logic                    rst;
    logic                    pv;
    logic                    clr;
    logic                    rdy;
    logic signed [63:0]      prod;
    int                      e_cnt;
    logic                    e_vld;
    logic signed [ACC_W-1:0] e_sum;
    logic                    e_ovf;
    logic                    e_drop;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N_TERMS=4 instance
  logic                    rst4, pv4, clr4, rdy4;
  logic signed [63:0]      prod4;
  logic signed [ACC_W-1:0] sum4;
  logic                    ovf4, vld4, drop4;
  logic [2:0]              cnt4;

  // N_TERMS=8 instance
  logic                    rst8, pv8, clr8, rdy8;
  logic signed [63:0]      prod8;
  logic signed [ACC_W-1:0] sum8;
  logic                    ovf8, vld8, drop8;
  logic [3:0]              cnt8;

  booth_product_accumulator #(.ACC_W(ACC_W), .N_TERMS(4), .FIFO_DEPTH(2)) u4 (
    .CLK(clk), .RST(rst4), .Product(prod4), .Product_Valid(pv4), .Acc_Clear(clr4),
    .Sum_Out(sum4), .Sum_Ovf(ovf4), .Sum_Valid(vld4), .Sum_Ready(rdy4),
    .Drop(drop4), .Term_Cnt(cnt4)
  );

  booth_product_accumulator #(.ACC_W(ACC_W), .N_TERMS(8), .FIFO_DEPTH(2)) u8 (
    .CLK(clk), .RST(rst8), .Product(prod8), .Product_Valid(pv8), .Acc_Clear(clr8),
    .Sum_Out(sum8), .Sum_Ovf(ovf8), .Sum_Valid(vld8), .Sum_Ready(rdy8),
    .Drop(drop8), .Term_Cnt(cnt8)
  );

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic signed [67:0] act,
                     input logic signed [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic pv, input logic clr, input logic rdy,
                     input longint prod, input int cnt, input logic vld,
                     input logic signed [ACC_W-1:0] sum, input logic drop);
    vec_t v;
    v.rst = rst; v.pv = pv; v.clr = clr; v.rdy = rdy; v.prod = prod;
    v.e_cnt = cnt; v.e_vld = vld; v.e_sum = sum; v.e_ovf = 1'b0; v.e_drop = drop;
    vecs.push_back(v);
  endtask

  task automatic step4(input logic rst, input logic pv, input logic clr,
                       input logic rdy, input longint prod);
    rst4 = rst; pv4 = pv; clr4 = clr; rdy4 = rdy; prod4 = prod;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int cnt, input logic vld,
                      input logic signed [ACC_W-1:0] sum, input logic ovf,
                      input logic drop);
    chk({tag, " cnt"},  cnt4,  cnt);
    chk({tag, " vld"},  vld4,  vld);
    chk({tag, " sum"},  sum4,  sum);
    chk({tag, " ovf"},  ovf4,  ovf);
    chk({tag, " drop"}, drop4, drop);
  endtask

  task automatic step8(input logic pv, input logic rdy, input longint prod);
    pv8 = pv; rdy8 = rdy; prod8 = prod;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input int cnt, input logic vld,
                      input logic signed [ACC_W-1:0] sum, input logic ovf,
                      input logic drop);
    chk({tag, " cnt"},  cnt8,  cnt);
    chk({tag, " vld"},  vld8,  vld);
    chk({tag, " sum"},  sum8,  sum);
    chk({tag, " ovf"},  ovf8,  ovf);
    chk({tag, " drop"}, drop8, drop);
  endtask

  initial begin
    logic signed [ACC_W-1:0] pmax;
    longint                  big;
    pmax = {1'b0, {(ACC_W-1){1'b1}}};
    big  = 64'sh7FFF_FFFF_FFFF_FFFF;

    //  rst pv clr rdy prod   cnt vld sum  drop
    add(1, 0, 0, 1,    0,     0, 0,   0, 0);   // reset state
    // group 15,-7,100,-8 with Ready high
    add(0, 1, 0, 1,   15,     1, 0,   0, 0);
    add(0, 1, 0, 1,   -7,     2, 0,   0, 0);
    add(0, 1, 0, 1,  100,     3, 0,   0, 0);
    add(0, 1, 0, 1,   -8,     0, 1, 100, 0);
    add(0, 0, 0, 1,    0,     0, 0, 100, 0);
    // three groups with Ready low: third one dropped
    for (int g = 1; g <= 3; g++) begin
      for (int t = 1; t <= 4; t++) begin
        add(0, 1, 0, 0, g, t % 4, (g > 1) || (t == 4), (g > 1 || t == 4) ? 4 : 100,
            (g == 3) && (t == 4));
      end
    end
    add(0, 0, 0, 0,    0,     0, 1,   4, 0);
    add(0, 0, 0, 1,    0,     0, 1,   8, 0);
    add(0, 0, 0, 1,    0,     0, 0,   8, 0);
    // fill with 40, 80, then 120 closes while popping
    for (int t = 1; t <= 4; t++) add(0, 1, 0, 0, 10, t % 4, t == 4, (t == 4) ? 40 : 8, 0);
    for (int t = 1; t <= 4; t++) add(0, 1, 0, 0, 20, t % 4, 1, 40, 0);
    for (int t = 1; t <= 3; t++) add(0, 1, 0, 0, 30, t, 1, 40, 0);
    add(0, 1, 0, 1,   30,     0, 1,  80, 0);
    add(0, 0, 0, 1,    0,     0, 1, 120, 0);
    add(0, 0, 0, 1,    0,     0, 0, 120, 0);
    // clear coinciding with a product
    add(0, 1, 0, 1,   50,     1, 0, 120, 0);
    add(0, 1, 0, 1,   60,     2, 0, 120, 0);
    add(0, 1, 1, 1,   70,     0, 0, 120, 0);
    add(0, 1, 0, 1,    1,     1, 0, 120, 0);
    add(0, 1, 0, 1,    2,     2, 0, 120, 0);
    add(0, 1, 0, 1,    3,     3, 0, 120, 0);
    add(0, 1, 0, 1,    4,     0, 1,  10, 0);
    add(0, 0, 0, 1,    0,     0, 0,  10, 0);

    rst8 = 1'b1; pv8 = 1'b0; clr8 = 1'b0; rdy8 = 1'b0; prod8 = '0;
    foreach (vecs[i]) begin
      step4(vecs[i].rst, vecs[i].pv, vecs[i].clr, vecs[i].rdy, vecs[i].prod);
      rst8 = 1'b0;
      chk4($sformatf("v%0d", i), vecs[i].e_cnt, vecs[i].e_vld, vecs[i].e_sum,
           vecs[i].e_ovf, vecs[i].e_drop);
    end

    // reset mid-group with one sum buffered
    for (int t = 1; t <= 4; t++) step4(0, 1, 0, 0, 7);
    chk4("t6 buffered", 0, 1, 28, 0, 0);
    step4(0, 1, 0, 0, 5);
    step4(0, 1, 0, 0, 5);
    chk4("t6 mid", 2, 1, 28, 0, 0);
    step4(1, 0, 0, 0, 0);
    chk4("t6 reset", 0, 0, 0, 0, 0);
    for (int t = 1; t <= 4; t++) step4(0, 1, 0, 0, 5);
    chk4("t6 after", 0, 1, 20, 0, 0);
    step4(0, 0, 0, 0, 0);

    // saturating group on the 8-term instance
    chk8("t2 reset", 0, 0, 0, 0, 0);
    for (int t = 1; t <= 8; t++) begin
      step8(1, 0, big);
      if (t < 8) chk8($sformatf("t2 sat t%0d", t), t, 0, 0, 0, 0);
    end
    chk8("t2 sat sum", 0, 1, pmax, 1, 0);
    for (int t = 1; t <= 8; t++) begin
      step8(1, 1, -1);
      if (t == 1) chk8("t2 pop held", 1, 0, pmax, 1, 0);
    end
    chk8("t2 neg sum", 0, 1, -8, 0, 0);
    step8(0, 1, 0);
    chk8("t2 drained", 0, 0, -8, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
